// File: rtl/mul_dispatch.sv
// mul_dispatch: queues multiply requests and issues them one at a time to a multi-cycle
// multiply unit, then holds the result for writeback. Watchdog: define MUL_DISPATCH_TIMEOUT_EN.
module mul_dispatch #(
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd,
  output logic        fu_en,
  output logic [31:0] fu_a,
  output logic [31:0] fu_b,
  input  logic [31:0] fu_res,
  input  logic        fu_finish,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy
`ifdef MUL_DISPATCH_TIMEOUT_EN
  ,
  output logic        timeout_err
`endif
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } req_t;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
    $error("mul_dispatch: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  req_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          push;
  logic          pop;
  logic          expire;
  logic [4:0]    op_rd;
  state_t        state;
  state_t        state_next;

  assign req_ready = (count != (PW+1)'(DEPTH));
  assign push      = req_valid && req_ready;
  assign pop       = (state == IDLE) && (count != '0);

  // NOTE: storage array is deliberately not reset; count/pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{a: req_a, b: req_b, rd: req_rd};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (count != '0) state_next = ISSUE;
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (fu_finish)   state_next = (op_rd == 5'd0) ? IDLE : WB;
        else if (expire) state_next = IDLE;
      end
      WB:      if (wb_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operands are latched as the head is popped, so they hold from ISSUE to the next ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      fu_a    <= '0;
      fu_b    <= '0;
      op_rd   <= '0;
      wb_data <= '0;
    end else begin
      if (pop) begin
        fu_a  <= mem[rd_ptr].a;
        fu_b  <= mem[rd_ptr].b;
        op_rd <= mem[rd_ptr].rd;
      end
      if (state == WAIT && fu_finish) wb_data <= fu_res;
    end
  end

`ifdef MUL_DISPATCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;

  // wait_cnt holds the number of WAIT cycles already completed; fire on the TIMEOUT-th.
  assign expire = (state == WAIT) && (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == ISSUE)     wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + CW'(1);
      if (expire && !fu_finish) timeout_err <= 1'b1;
    end
  end
`else
  assign expire = 1'b0;
`endif

  assign fu_en    = (state == ISSUE);
  assign wb_valid = (state == WB);
  assign wb_rd    = op_rd;
  assign busy     = (count != '0) || (state != IDLE);

endmodule
